// File: rtl/dpr_loader_pkg.sv
// Shared definitions for the distributed processor command-memory loader:
// loader FSM states and the default bank geometry used by this block and
// by the command memory instantiation.
package dpr_loader_pkg;

  localparam int DPR_MEM_WIDTH      = 32;
  localparam int DPR_MEM_TO_CMD     = 4;
  localparam int DPR_CMD_ADDR_WIDTH = 8;
  localparam int DPR_CMD_WIDTH      = DPR_MEM_WIDTH * DPR_MEM_TO_CMD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } loader_state_e;

  // Width of a counter selecting one of n lanes (at least one bit).
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_mem_loader_if.sv
// Word stream (valid/ready) plus command memory write port of the loader.
// master: host side (drives words, observes the write port).
// slave : loader side.
interface cmd_mem_loader_if
  import dpr_loader_pkg::*;
#(
  parameter int MEM_WIDTH      = DPR_MEM_WIDTH,
  parameter int MEM_TO_CMD     = DPR_MEM_TO_CMD,
  parameter int CMD_ADDR_WIDTH = DPR_CMD_ADDR_WIDTH
) ();

  logic [MEM_WIDTH-1:0]            word_in;
  logic                            word_valid;
  logic                            word_ready;
  logic [CMD_ADDR_WIDTH-1:0]       cmd_write_addr;
  logic [MEM_WIDTH*MEM_TO_CMD-1:0] cmd_write;
  logic                            cmd_write_enable;

  modport master (
    output word_in, word_valid,
    input  word_ready, cmd_write_addr, cmd_write, cmd_write_enable
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, cmd_write_addr, cmd_write, cmd_write_enable
  );

endinterface

// File: rtl/cmd_word_packer.sv
// Lane counter and packing register: collects MEM_TO_CMD words, lane 0 in
// the LSBs. cmd_o already contains the word being pushed, so the full
// command is available in the same cycle complete_o is raised.
module cmd_word_packer
  import dpr_loader_pkg::*;
#(
  parameter int MEM_WIDTH  = DPR_MEM_WIDTH,
  parameter int MEM_TO_CMD = DPR_MEM_TO_CMD
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clr_i,
  input  logic                            push_i,
  input  logic [MEM_WIDTH-1:0]            word_i,
  output logic [MEM_WIDTH*MEM_TO_CMD-1:0] cmd_o,
  output logic                            complete_o
);

  localparam int                LANE_W    = lane_bits(MEM_TO_CMD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MEM_TO_CMD - 1);

  logic [LANE_W-1:0]               lane_q;
  logic [MEM_WIDTH*MEM_TO_CMD-1:0] pack_q;
  logic [MEM_WIDTH*MEM_TO_CMD-1:0] pack_d;

  // Insert the incoming word into its lane of the packing register.
  always_comb begin
    pack_d = pack_q;
    pack_d[int'(lane_q)*MEM_WIDTH +: MEM_WIDTH] = word_i;
  end

  // Advance lane counter and capture words; reset discards partial commands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= {LANE_W{1'b0}};
      pack_q <= {(MEM_WIDTH*MEM_TO_CMD){1'b0}};
    end else if (clr_i) begin
      lane_q <= {LANE_W{1'b0}};
      pack_q <= pack_q;
    end else if (push_i) begin
      pack_q <= pack_d;
      lane_q <= (lane_q == LAST_LANE) ? {LANE_W{1'b0}} : lane_q + LANE_W'(1);
    end else begin
      lane_q <= lane_q;
      pack_q <= pack_q;
    end
  end

  assign cmd_o      = pack_d;
  assign complete_o = push_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/cmd_mem_loader.sv
// Command memory loader: packs MEM_TO_CMD input words per command and writes
// them at consecutive (wrapping) addresses from base_addr, holding the core
// in reset while loading.
// Optional feature: define CMD_MEM_LOADER_CHECKSUM_EN to build the running
// sum of accepted words on checksum; otherwise checksum is tied to 0.
module cmd_mem_loader
  import dpr_loader_pkg::*;
#(
  parameter int CMD_WIDTH      = DPR_CMD_WIDTH,
  parameter int CMD_ADDR_WIDTH = DPR_CMD_ADDR_WIDTH,
  parameter int MEM_WIDTH      = DPR_MEM_WIDTH,
  parameter int MEM_TO_CMD     = DPR_MEM_TO_CMD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
  input  logic [CMD_ADDR_WIDTH:0]   num_cmds,
  cmd_mem_loader_if.slave           bus,
  output logic                      proc_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap,
  output logic [MEM_WIDTH-1:0]      checksum
);

  localparam int CNT_W = CMD_ADDR_WIDTH + 1;

  loader_state_e             state_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      wrap_q;
  logic                      we_q;
  logic [CMD_ADDR_WIDTH-1:0] addr_q;
  logic [CMD_ADDR_WIDTH-1:0] waddr_q;
  logic [CNT_W-1:0]          left_q;
  logic [CMD_WIDTH-1:0]      cmd_q;

  logic                      start_acc_s;
  logic                      hs_s;
  logic                      cmd_done_s;
  logic [CMD_WIDTH-1:0]      cmd_full_s;

  // start is only honoured in IDLE; ready_q is high exactly in LOAD.
  assign start_acc_s = start && (state_q == IDLE);
  assign hs_s        = bus.word_valid && ready_q;

  cmd_word_packer #(
    .MEM_WIDTH  (MEM_WIDTH),
    .MEM_TO_CMD (MEM_TO_CMD)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (start_acc_s),
    .push_i     (hs_s),
    .word_i     (bus.word_in),
    .cmd_o      (cmd_full_s),
    .complete_o (cmd_done_s)
  );

  // Loader FSM with address/command counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {CMD_ADDR_WIDTH{1'b0}};
      waddr_q <= {CMD_ADDR_WIDTH{1'b0}};
      left_q  <= {CNT_W{1'b0}};
      cmd_q   <= {CMD_WIDTH{1'b0}};
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= base_addr;
            left_q <= num_cmds;
            wrap_q <= 1'b0;
            if (num_cmds == {CNT_W{1'b0}}) begin
              done_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cmd_done_s) begin
            we_q    <= 1'b1;
            waddr_q <= addr_q;
            cmd_q   <= cmd_full_s;
            addr_q  <= addr_q + CMD_ADDR_WIDTH'(1);
            left_q  <= left_q - CNT_W'(1);
            // Wrap only matters if another command will land at address 0.
            if ((&addr_q) && (left_q != CNT_W'(1))) begin
              wrap_q <= 1'b1;
            end
            if (left_q == CNT_W'(1)) begin
              state_q <= FLUSH;
              ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  logic [MEM_WIDTH-1:0] checksum_q;

  // Wrapping sum of accepted words, cleared by an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= {MEM_WIDTH{1'b0}};
    end else if (start_acc_s) begin
      checksum_q <= {MEM_WIDTH{1'b0}};
    end else if (hs_s) begin
      checksum_q <= checksum_q + bus.word_in;
    end else begin
      checksum_q <= checksum_q;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = {MEM_WIDTH{1'b0}};
`endif

  assign bus.word_ready       = ready_q;
  assign bus.cmd_write_enable = we_q;
  assign bus.cmd_write_addr   = waddr_q;
  assign bus.cmd_write        = cmd_q;
  assign busy                 = busy_q;
  assign proc_hold            = busy_q;
  assign done                 = done_q;
  assign wrap                 = wrap_q;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Scoreboard bench for cmd_mem_loader: stimulus pushes expected writes
// (address, data, strobe cycle); a negedge monitor pops and compares.
module tb_cmd_mem_loader;
  import dpr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [8:0]  num_cmds = 9'h000;
  logic        proc_hold, busy, done, wrap;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [31:0]  cyc;
  } exp_t;
  exp_t sb[$];

  // bench model of the load in progress
  logic [7:0]   m_addr;
  logic [127:0] m_cmd;
  logic [31:0]  m_sum;
  int           m_lane;

  cmd_mem_loader_if bus ();

  cmd_mem_loader dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .num_cmds  (num_cmds),
    .bus       (bus.slave),
    .proc_hold (proc_hold),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.cmd_write_enable) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got addr %0h expected no strobe", bus.cmd_write_addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", {120'h0, bus.cmd_write_addr}, {120'h0, e.addr});
        chk("wr_data", bus.cmd_write, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, bus.word_ready, 1'b0);
    chk({tag, "_we"}, bus.cmd_write_enable, 1'b0);
    chk({tag, "_addr"}, bus.cmd_write_addr, 8'h00);
    chk({tag, "_data"}, bus.cmd_write, 128'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_hold"}, proc_hold, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wrap"}, wrap, 1'b0);
    chk({tag, "_cksum"}, checksum, 32'h0);
  endtask

  // called just after a posedge; start is seen at the next posedge
  task automatic start_load(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1;
    base_addr = b;
    num_cmds = n;
    m_addr = b;
    m_lane = 0;
    m_sum = 32'h0;
    m_cmd = 128'h0;
    @(posedge clk); #1;
    start = 1'b0;
    if (n != 9'h0) begin
      chk("start_busy", busy, 1'b1);
      chk("start_ready", bus.word_ready, 1'b1);
      chk("start_hold", proc_hold, 1'b1);
    end else begin
      chk("empty_done", done, 1'b1);
      chk("empty_busy", busy, 1'b0);
      chk("empty_ready", bus.word_ready, 1'b0);
      @(posedge clk); #1;
      chk("empty_done_pulse", done, 1'b0);
    end
  endtask

  task automatic send(input logic [31:0] w, input int gap, input bit strict);
    int waited = 0;
    for (int i = 0; i < gap; i++) begin
      bus.word_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.word_valid = 1'b1;
    bus.word_in = w;
    while (!bus.word_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.word_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got word_ready 0 expected 1");
      bus.word_valid = 1'b0;
    end else begin
      if (strict) chk("ready_no_drop", waited, 0);
      chk("hold_in_load", proc_hold, 1'b1);
      m_cmd[m_lane*32 +: 32] = w;
      m_sum = m_sum + w;
      m_lane++;
      if (m_lane == 4) begin
        sb.push_back({m_addr, m_cmd, cyc + 32'd1});
        m_addr = m_addr + 8'd1;
        m_lane = 0;
      end
      @(posedge clk); #1;
      bus.word_valid = 1'b0;
    end
  endtask

  // called in the strobe cycle following the last handshake
  task automatic finish_check();
    chk("flush_ready", bus.word_ready, 1'b0);
    chk("flush_busy", busy, 1'b1);
    chk("flush_done", done, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_hold", proc_hold, 1'b0);
    chk("checksum", checksum, exp_ck(m_sum));
    @(posedge clk); #1;
    chk("done_clear", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.word_valid = 1'b0;
    bus.word_in = 32'h0;
    #3;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single command
    start_load(8'h00, 9'd1);
    send(32'h11111111, 0, 1'b1);
    send(32'h22222222, 0, 1'b1);
    send(32'h33333333, 0, 1'b1);
    send(32'h44444444, 0, 1'b1);
    finish_check();
    chk("single_data", bus.cmd_write, 128'h44444444_33333333_22222222_11111111);
    chk("single_addr", bus.cmd_write_addr, 8'h00);
    chk("single_cksum", checksum, exp_ck(32'hAAAAAAAA));

    // streaming two commands from address 5
    start_load(8'h05, 9'd2);
    for (int i = 0; i < 8; i++) send(32'hA0000000 + i, 0, 1'b1);
    finish_check();
    chk("stream_last_addr", bus.cmd_write_addr, 8'h06);

    // same load with stalls and an ignored start in the middle
    start_load(8'h05, 9'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1;
        base_addr = 8'h40;
        num_cmds = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send(32'hA0000000 + i, 1, 1'b0);
    end
    finish_check();
    chk("stall_last_data", bus.cmd_write, 128'hA0000007_A0000006_A0000005_A0000004);

    // empty load
    start_load(8'h33, 9'd0);

    // wrap past the top address
    start_load(8'hFF, 9'd2);
    send(32'h0000000F, 0, 1'b1);
    send(32'h000000F0, 0, 1'b1);
    send(32'h00000F00, 0, 1'b1);
    chk("wrap_before", wrap, 1'b0);
    send(32'h0000F000, 0, 1'b1);
    chk("wrap_set", wrap, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h00010000 << i, 0, 1'b1);
    finish_check();
    chk("wrap_sticky", wrap, 1'b1);
    chk("wrap_last_addr", bus.cmd_write_addr, 8'h00);
    start_load(8'h00, 9'd0);
    chk("wrap_cleared", wrap, 1'b0);

    // reset in the middle of a load
    start_load(8'h10, 9'd1);
    send(32'hDEADBEEF, 0, 1'b1);
    send(32'hCAFEF00D, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    m_lane = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_load(8'h20, 9'd1);
    send(32'h01020304, 0, 1'b1);
    send(32'h05060708, 0, 1'b1);
    send(32'h090A0B0C, 0, 1'b1);
    send(32'h0D0E0F10, 0, 1'b1);
    finish_check();
    chk("postrst_data", bus.cmd_write, 128'h0D0E0F10_090A0B0C_05060708_01020304);
    chk("postrst_addr", bus.cmd_write_addr, 8'h20);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_mem_loader.md
# cmd_mem_loader

Host-side writer for the distributed processor's command memory. Accepts a stream of MEM_WIDTH-bit words over a valid/ready handshake, packs MEM_TO_CMD consecutive words into one CMD_WIDTH-bit command, and drives the command memory write port (cmd_write_addr / cmd_write / cmd_write_enable) at consecutive addresses from a programmed base. While a load is in progress it holds the processor core in reset, so the core never fetches a partially written program.

## Interface
- CMD_WIDTH, 128, command width; must equal MEM_WIDTH*MEM_TO_CMD
- CMD_ADDR_WIDTH, 8, command memory address width
- MEM_WIDTH, 32, width of one input word and one memory bank
- MEM_TO_CMD, 4, words per command (the number of memory banks)

- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- start  in  1  single-cycle load request; sampled only in IDLE
- base_addr  in  CMD_ADDR_WIDTH  first command address; latched on start
- num_cmds  in  CMD_ADDR_WIDTH+1  number of commands to load (0..2^CMD_ADDR_WIDTH); latched on start
- word_in  in  MEM_WIDTH  input data word
- word_valid  in  1  word_in valid
- word_ready  out  1  loader accepts word_in this cycle
- cmd_write_addr  out  CMD_ADDR_WIDTH  memory write address
- cmd_write  out  CMD_WIDTH  assembled command
- cmd_write_enable  out  1  one-cycle write strobe
- proc_hold  out  1  processor reset request; high while busy
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load
- wrap  out  1  sticky: address wrapped past 2^CMD_ADDR_WIDTH-1; cleared on next accepted start
- checksum  out  MEM_WIDTH  modulo-2^MEM_WIDTH sum of accepted words (see Configuration)

## Operation
- States: IDLE, LOAD, FLUSH.
- IDLE: word_ready=0. start=1 latches base_addr/num_cmds, clears lane counter, command counter, wrap, and checksum. If num_cmds=0, stay in IDLE and pulse done next cycle; otherwise go to LOAD.
- LOAD: word_ready=1. A handshake (word_valid & word_ready) stores word_in into lane k, bits [MEM_WIDTH*(k+1)-1 : MEM_WIDTH*k], and increments k. The first word is lane 0 (LSBs).
- On the handshake that fills lane MEM_TO_CMD-1, a write is registered: next cycle cmd_write_enable=1 with the full command at the current address. Address then increments modulo 2^CMD_ADDR_WIDTH, and k resets to 0. If that increment goes from all-ones to 0 and commands remain, wrap is set. Writing continues at the wrapped address.
- If that handshake completes the last command, go to FLUSH. FLUSH lasts one cycle (the write strobe cycle), then returns to IDLE with done=1.
- start outside IDLE is ignored.
- busy = proc_hold = (state != IDLE).
- cmd_write and cmd_write_addr hold their last values outside strobe cycles; consumers qualify them with cmd_write_enable only.

## Timing
- Reset values: word_ready=0, cmd_write_addr=0, cmd_write=0, cmd_write_enable=0, proc_hold=0, busy=0, done=0, wrap=0, checksum=0. State is IDLE.
- start at cycle T: busy and word_ready are 1 from T+1.
- Throughput is one word per cycle. A strobe in the same cycle as a new handshake is legal, and word_ready never drops inside LOAD.
- Last handshake at cycle T: cmd_write_enable at T+1 (FLUSH, word_ready=0), done at T+2, and busy falls at T+2.
- With num_cmds=0: start at T gives done at T+1, with no strobe and busy staying 0.
- Reset asserted mid-load: all outputs and state go asynchronously to their reset values. A partial command is discarded and never written.

## Configuration
- CMD_MEM_LOADER_CHECKSUM_EN defined: checksum accumulates each accepted word_in (wrapping add) and is cleared on accepted start. It holds its value after done.
- Not defined: no accumulator is built, and checksum is tied to 0.

## Structure
- Shared package dpr_loader_pkg holds the state enum typedef (IDLE, LOAD, FLUSH) and the default MEM_TO_CMD / MEM_WIDTH constants used by both this block and the memory instantiation.
- One sub-module, cmd_word_packer: lane counter plus packing register, with a "command complete" output. The FSM, address counter and command counter stay in the top.

## Test plan
- Single command: base_addr=0, num_cmds=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with continuous valid -> one strobe at addr 0, cmd_write=0x44444444_33333333_22222222_11111111, done 2 cycles after the 4th handshake, checksum=0xAAAAAAAA (0 without the macro).
- Streaming: base_addr=5, num_cmds=2, 8 back-to-back words -> strobes at addr 5 and 6 exactly 4 cycles apart, word_ready stays 1 until the 8th handshake, proc_hold high for the whole load.
- Stalls: same load with word_valid low on alternate cycles -> identical write data/addresses, each strobe one cycle after its 4th handshake.
- Empty/ignored: num_cmds=0 -> done at T+1 with no strobe. A second start pulse during LOAD -> no effect on counts or addresses.
- Wrap: base_addr=0xFF, num_cmds=2 -> strobes at 0xFF then 0x00, wrap=1 after the 0xFF write, wrap cleared by the next start.
- Reset mid-load: assert reset after 2 accepted words -> all outputs 0 immediately. After release, a new 1-command load writes only the new 4 words, with no stale lanes.
